// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding, bundle bit indices and constants for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RESET      = 2'd0,
    ST_RUN        = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_TRAP_FLUSH = 2'd3
  } state_t;

  // Bit positions inside the 4-bit stall bundle
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;

  // Bit positions inside the 4-bit flush bundle
  localparam int FLUSH_IFID  = 0;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_EXMEM = 2;
  localparam int FLUSH_MEMWB = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - 8-bit data-memory wait counter with clear, enable and timeout flag
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  logic [7:0] count;

  // Count consecutive wait cycles; clear has priority over enable
  always_ff @(posedge clk_i) begin
    if (!reset_i || clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign timeout = (count == TIMEOUT_V);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush sequencer with load-use detection and dmem freeze
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             idex_wb,
  input  logic             branch_taken,
  input  logic             trap_req,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // Remaining flush cycles after the entry cycle of TRAP_FLUSH
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic       trap_pend, pend_nxt;
  logic [7:0] fcnt, fcnt_nxt;
  logic [3:0] stall_v, flush_v;
  logic       timer_en, timer_clr, timeout;
  logic       wait_c, load_use;

  // idex_wb is active-low; x0 is never a real producer
  assign load_use = idex_mem_read & ~idex_wb & (idex_rd != REG_ZERO) &
                    ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                     (ifid_use_rs2 & (ifid_rs2 == idex_rd)));
  assign wait_c = dmem_req & ~dmem_ack;

  mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr    (timer_clr),
    .en     (timer_en),
    .timeout(timeout)
  );

  // Output decode and next-state decision; RUN checks follow the fixed priority order
  always_comb begin
    state_nxt = state;
    pend_nxt  = trap_pend;
    fcnt_nxt  = fcnt;
    stall_v   = 4'b0000;
    flush_v   = 4'b0000;
    bus_err   = 1'b0;
    timer_en  = 1'b0;
    timer_clr = 1'b1;
    case (state)
      ST_RESET: begin
        flush_v   = 4'b1111;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (wait_c) begin
          // Freeze starts on the entry cycle and counts as the first wait cycle
          stall_v              = 4'b1111;
          flush_v[FLUSH_MEMWB] = 1'b1;
          timer_en             = 1'b1;
          timer_clr            = 1'b0;
          state_nxt            = ST_MEM_WAIT;
          if (trap_req) pend_nxt = 1'b1;
        end else if (trap_req || trap_pend) begin
          state_nxt = ST_TRAP_FLUSH;
          fcnt_nxt  = FLUSH_LAST;
          pend_nxt  = 1'b0;
        end else if (branch_taken) begin
          flush_v[FLUSH_IFID] = 1'b1;
          flush_v[FLUSH_IDEX] = 1'b1;
        end else if (load_use) begin
          stall_v[STALL_PC]   = 1'b1;
          stall_v[STALL_IFID] = 1'b1;
          flush_v[FLUSH_IDEX] = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        stall_v              = 4'b1111;
        flush_v[FLUSH_MEMWB] = 1'b1;
        if (trap_req) pend_nxt = 1'b1;
        if (dmem_ack) begin
          state_nxt = ST_RUN;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = ST_TRAP_FLUSH;
          fcnt_nxt  = FLUSH_LAST;
          pend_nxt  = 1'b0;
        end else begin
          timer_en  = 1'b1;
          timer_clr = 1'b0;
        end
      end
      ST_TRAP_FLUSH: begin
        flush_v[FLUSH_IFID]  = 1'b1;
        flush_v[FLUSH_IDEX]  = 1'b1;
        flush_v[FLUSH_EXMEM] = 1'b1;
        if (trap_req) begin
          fcnt_nxt = FLUSH_LAST;
        end else if (fcnt == 8'd0) begin
          state_nxt = ST_RUN;
        end else begin
          fcnt_nxt = fcnt - 8'd1;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  assign pc_stall    = stall_v[STALL_PC];
  assign ifid_stall  = stall_v[STALL_IFID];
  assign idex_stall  = stall_v[STALL_IDEX];
  assign exmem_stall = stall_v[STALL_EXMEM];
  assign ifid_flush  = flush_v[FLUSH_IFID];
  assign idex_flush  = flush_v[FLUSH_IDEX];
  assign exmem_flush = flush_v[FLUSH_EXMEM];
  assign memwb_flush = flush_v[FLUSH_MEMWB];

  // State, pending trap, flush countdown and saturating stall counter
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= ST_RESET;
      trap_pend <= 1'b0;
      fcnt      <= 8'd0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      trap_pend <= pend_nxt;
      fcnt      <= fcnt_nxt;
      if (stall_v[STALL_PC] && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 4;

  // Output vector order: {pc,ifid,idex,exmem stall, ifid,idex,exmem,memwb flush, bus_err}
  localparam logic [8:0] O_IDLE   = 9'b0000_0000_0;
  localparam logic [8:0] O_RESET  = 9'b0000_1111_0;
  localparam logic [8:0] O_FROZEN = 9'b1111_0001_0;
  localparam logic [8:0] O_BUSERR = 9'b1111_0001_1;
  localparam logic [8:0] O_TRAP   = 9'b0000_1110_0;
  localparam logic [8:0] O_BRANCH = 9'b0000_1100_0;
  localparam logic [8:0] O_LU     = 9'b1100_0100_0;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [4:0]    ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic          ifid_use_rs1 = 0, ifid_use_rs2 = 0, idex_mem_read = 0, idex_wb = 1;
  logic          branch_taken = 0, trap_req = 0, dmem_req = 0, dmem_ack = 0;
  logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, bus_err;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_controller #(
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT),
    .CNT_W       (CW)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .idex_rd      (idex_rd),
    .idex_mem_read(idex_mem_read),
    .idex_wb      (idex_wb),
    .branch_taken (branch_taken),
    .trap_req     (trap_req),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .exmem_stall  (exmem_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .bus_err      (bus_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [8:0] obs();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, bus_err};
  endfunction

  task automatic idle_inputs();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
    ifid_use_rs1 = 0; ifid_use_rs2 = 0; idex_mem_read = 0; idex_wb = 1;
    branch_taken = 0; trap_req = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the DUT in its first RUN cycle with idle inputs
  task automatic do_reset();
    idle_inputs();
    reset_i = 0;
    next_cycle();
    reset_i = 1;
    next_cycle();
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    idex_mem_read = 1; idex_wb = 0; idex_rd = rd;
    ifid_rs1 = rs1; ifid_use_rs1 = u1; ifid_rs2 = rs2; ifid_use_rs2 = u2;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 0;
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (obs() !== O_RESET) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs(), O_RESET);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    reset_i = 1;
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (obs() !== O_IDLE) begin
      errors++; $display("FAIL reset_to_run: got %b want %b", obs(), O_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    @(negedge clk_i);
    checks++;
    if (obs() !== O_LU) begin
      errors++; $display("FAIL load_use_stall: got %b want %b", obs(), O_LU);
    end
    next_cycle();
    idex_mem_read = 0; idex_wb = 1;
    @(negedge clk_i);
    checks++;
    if (obs() !== O_IDLE) begin
      errors++; $display("FAIL load_use_release: got %b want %b", obs(), O_IDLE);
    end
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_no_stall();
    logic [8:0] o;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        1: set_load(5'd5, 5'd5, 1'b0, 5'd7, 1'b1);
        default: begin set_load(5'd5, 5'd5, 1'b1, 5'd5, 1'b1); idex_wb = 1; end
      endcase
      @(negedge clk_i);
      o = obs();
      checks++;
      if (o !== O_IDLE) begin
        errors++; $display("FAIL no_stall_case%0d: got %b want %b", k, o, O_IDLE);
      end
      next_cycle();
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL no_stall_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    branch_taken = 1;
    for (int c = 0; c < 5; c++) begin
      dmem_req = (c < 4);
      dmem_ack = (c == 3);
      @(negedge clk_i);
      checks++;
      if (obs() !== ((c < 4) ? O_FROZEN : O_BRANCH)) begin
        errors++;
        $display("FAIL mem_wait_c%0d: got %b want %b", c, obs(), (c < 4) ? O_FROZEN : O_BRANCH);
      end
      next_cycle();
    end
    @(negedge clk_i);
    checks++;
    if (stall_cnt !== 4'd4) begin
      errors++; $display("FAIL mem_wait_cnt: got %0d want 4", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic [8:0] e [8] = '{O_FROZEN, O_FROZEN, O_FROZEN, O_FROZEN, O_BUSERR, O_TRAP, O_TRAP, O_IDLE};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      dmem_req = (c < 5);
      @(negedge clk_i);
      checks++;
      if (obs() !== e[c]) begin
        errors++; $display("FAIL timeout_c%0d: got %b want %b", c, obs(), e[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_trap_in_wait();
    logic [8:0] e [7] = '{O_FROZEN, O_FROZEN, O_FROZEN, O_IDLE, O_TRAP, O_TRAP, O_IDLE};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      dmem_req = (c < 3);
      dmem_ack = (c == 2);
      trap_req = (c == 1);
      @(negedge clk_i);
      checks++;
      if (obs() !== e[c]) begin
        errors++; $display("FAIL trap_in_wait_c%0d: got %b want %b", c, obs(), e[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    next_cycle();
    idle_inputs();
    trap_req = 1;
    next_cycle();
    trap_req = 0;
    @(negedge clk_i);
    checks++;
    if (obs() !== O_TRAP) begin
      errors++; $display("FAIL mid_flush_entry: got %b want %b", obs(), O_TRAP);
    end
    reset_i = 0;
    next_cycle();
    reset_i = 1;
    @(negedge clk_i);
    checks++;
    if (obs() !== O_RESET || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_flush_reset: got %b cnt %0d want %b cnt 0", obs(), stall_cnt, O_RESET);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (obs() !== O_IDLE) begin
      errors++; $display("FAIL mid_flush_run: got %b want %b", obs(), O_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      @(negedge clk_i);
      if (k == 14) begin
        checks++;
        if (stall_cnt !== 4'd14) begin
          errors++; $display("FAIL sat_before: got %0d want 14", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_hold: got %0d want 15", stall_cnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Reference model: pipeline mode tracked as counts of remaining wait/flush cycles
  task automatic test_random();
    bit         m_rst, m_frz, m_pend, lu;
    int         m_wait, m_fl, m_cnt;
    logic [8:0] exp_o;
    logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd17};
    do_reset();
    m_rst = 0; m_frz = 0; m_pend = 0; m_wait = 0; m_fl = 0; m_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      reset_i       = ($urandom_range(0, 99) != 0);
      dmem_req      = ($urandom_range(0, 4) == 0);
      dmem_ack      = ($urandom_range(0, 3) == 0);
      trap_req      = ($urandom_range(0, 15) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      idex_mem_read = 1'($urandom_range(0, 1));
      idex_wb       = ($urandom_range(0, 3) == 0);
      idex_rd       = regs[$urandom_range(0, 3)];
      ifid_rs1      = regs[$urandom_range(0, 3)];
      ifid_rs2      = regs[$urandom_range(0, 3)];
      ifid_use_rs1  = 1'($urandom_range(0, 1));
      ifid_use_rs2  = 1'($urandom_range(0, 1));
      lu = idex_mem_read && !idex_wb && idex_rd != 0 &&
           ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
      if (m_rst) exp_o = O_RESET;
      else if (m_frz) exp_o = (!dmem_ack && m_wait == MT) ? O_BUSERR : O_FROZEN;
      else if (m_fl > 0) exp_o = O_TRAP;
      else if (dmem_req && !dmem_ack) exp_o = O_FROZEN;
      else if (trap_req || m_pend) exp_o = O_IDLE;
      else if (branch_taken) exp_o = O_BRANCH;
      else if (lu) exp_o = O_LU;
      else exp_o = O_IDLE;
      @(negedge clk_i);
      checks++;
      if (obs() !== exp_o) begin
        errors++; $display("FAIL random_out i=%0d: got %b want %b", i, obs(), exp_o);
      end
      checks++;
      if (stall_cnt !== 4'(m_cnt)) begin
        errors++; $display("FAIL random_cnt i=%0d: got %0d want %0d", i, stall_cnt, m_cnt);
      end
      if (exp_o[8]) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      if (!reset_i) begin
        m_rst = 1; m_frz = 0; m_pend = 0; m_wait = 0; m_fl = 0; m_cnt = 0;
      end else if (m_rst) begin
        m_rst = 0;
      end else if (m_frz) begin
        if (trap_req) m_pend = 1;
        if (dmem_ack) begin
          m_frz = 0; m_wait = 0;
        end else if (m_wait == MT) begin
          m_frz = 0; m_wait = 0; m_fl = FC; m_pend = 0;
        end else begin
          m_wait++;
        end
      end else if (m_fl > 0) begin
        if (trap_req) m_fl = FC;
        else m_fl--;
      end else if (dmem_req && !dmem_ack) begin
        m_frz = 1; m_wait = 1;
        if (trap_req) m_pend = 1;
      end else if (trap_req || m_pend) begin
        m_fl = FC; m_pend = 0;
      end
      next_cycle();
    end
    reset_i = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_mem_wait();
    test_timeout();
    test_trap_in_wait();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
